// File: rtl/hub75_bitplane_slicer_if.sv
// Pixel-in / bit-plane-word-out stream bundle for hub75_bitplane_slicer.
// master = upstream/downstream side, slave = the slicer.
interface hub75_bitplane_slicer_if #(
  parameter int unsigned BITDEPTH = 10,
  parameter int unsigned N_PIX    = 4
);
  localparam int unsigned PLW = $clog2(BITDEPTH);

  logic [3*BITDEPTH-1:0] in_data;
  logic                  in_last;
  logic                  in_valid;
  logic                  in_ready;
  logic [3*N_PIX-1:0]    out_data;
  logic [PLW-1:0]        out_plane;
  logic                  out_last;
  logic                  out_valid;
  logic                  out_ready;

  modport master (
    output in_data, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_plane, out_last, out_valid
  );

  modport slave (
    input  in_data, in_last, in_valid, out_ready,
    output in_ready, out_data, out_plane, out_last, out_valid
  );
endinterface

// File: rtl/hub75_bitplane_slicer.sv
// Regroups N_PIX RGB pixels into BITDEPTH bit-plane words, MSB plane first.
// Define HUB75_SLICER_DBLBUF_EN for ping/pong group buffers (fill and emit overlap).
module hub75_bitplane_slicer #(
  parameter int unsigned BITDEPTH = 10,
  parameter int unsigned N_PIX    = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  hub75_bitplane_slicer_if.slave bus
);
  localparam int unsigned PLW  = $clog2(BITDEPTH);
  localparam int unsigned PixW = 3 * BITDEPTH;
  localparam int unsigned CntW = (N_PIX > 1) ? $clog2(N_PIX) : 1;

  typedef logic [N_PIX-1:0][PixW-1:0] group_t;

  // Store a pixel at slot; when closing, clear every slot above it (zero padding).
  function automatic group_t insert_px(group_t g, logic [CntW-1:0] slot,
                                       logic [PixW-1:0] px, logic pad);
    group_t r;
    r = g;
    for (int i = 0; i < N_PIX; i++) begin
      if (CntW'(i) == slot) r[i] = px;
      else if (pad && (CntW'(i) > slot)) r[i] = '0;
    end
    return r;
  endfunction

  function automatic logic [3*N_PIX-1:0] slice(group_t g, logic [PLW-1:0] p);
    logic [3*N_PIX-1:0] w;
    logic [BITDEPTH-1:0] rc, gc, bc;
    w = '0;
    for (int i = 0; i < N_PIX; i++) begin
      rc = g[i][3*BITDEPTH-1:2*BITDEPTH];
      gc = g[i][2*BITDEPTH-1:BITDEPTH];
      bc = g[i][BITDEPTH-1:0];
      w[3*i +: 3] = {rc[p], gc[p], bc[p]};
    end
    return w;
  endfunction

  typedef enum logic [0:0] {StFill, StEmit} state_e;

  group_t             grp0_q, grp0_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [PLW-1:0]     plane_q, plane_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q;
  logic [3*N_PIX-1:0] out_data_q, out_data_d;
  logic               out_last_q, out_last_d;
  state_e             state_q, state_d;
  logic               in_fire, out_fire, closing;
  group_t             fill_grp, new_grp, emit_grp;
  logic               emit_closed, emit_last, fill_closed;

`ifdef HUB75_SLICER_DBLBUF_EN
  group_t             grp1_q, grp1_d;
  logic [1:0]         closed_q, closed_d, glast_q, glast_d;
  logic               fb_q, fb_d, eb_q, eb_d;
`else
  logic               closed_q, closed_d, glast_q, glast_d;
`endif

  always_comb begin
    in_fire  = bus.in_valid & in_ready_q;
    out_fire = out_valid_q & bus.out_ready;
    closing  = in_fire & (bus.in_last | (cnt_q == CntW'(N_PIX - 1)));
    grp0_d   = grp0_q;
    cnt_d    = cnt_q;
    plane_d  = plane_q;
    closed_d = closed_q;
    glast_d  = glast_q;
    state_d  = state_q;
`ifdef HUB75_SLICER_DBLBUF_EN
    grp1_d   = grp1_q;
    fb_d     = fb_q;
    eb_d     = eb_q;
    fill_grp = fb_q ? grp1_q : grp0_q;
`else
    fill_grp = grp0_q;
`endif
    new_grp = insert_px(fill_grp, cnt_q, bus.in_data, closing);

    if (in_fire) begin
      cnt_d = closing ? '0 : cnt_q + CntW'(1);
`ifdef HUB75_SLICER_DBLBUF_EN
      if (fb_q) grp1_d = new_grp;
      else      grp0_d = new_grp;
      if (closing) begin
        closed_d[fb_q] = 1'b1;
        glast_d[fb_q]  = bus.in_last;
        fb_d           = ~fb_q;
      end
`else
      grp0_d = new_grp;
      if (closing) begin
        closed_d = 1'b1;
        glast_d  = bus.in_last;
      end
`endif
    end

    if (out_fire) begin
      if (plane_q == '0) begin
        state_d = StFill;
`ifdef HUB75_SLICER_DBLBUF_EN
        closed_d[eb_q] = 1'b0;
        eb_d           = ~eb_q;
`else
        closed_d = 1'b0;
`endif
      end else begin
        plane_d = plane_q - PLW'(1);
      end
    end

`ifdef HUB75_SLICER_DBLBUF_EN
    emit_grp    = eb_d ? grp1_d : grp0_d;
    emit_closed = closed_d[eb_d];
    emit_last   = glast_d[eb_d];
    fill_closed = closed_d[fb_d];
`else
    emit_grp    = grp0_d;
    emit_closed = closed_d;
    emit_last   = glast_d;
    fill_closed = closed_d;
`endif

    // A bank closed this edge (or waiting) starts emitting with no bubble.
    if ((state_d == StFill) && emit_closed) begin
      state_d = StEmit;
      plane_d = PLW'(BITDEPTH - 1);
    end

    in_ready_d = ~fill_closed;
    out_data_d = slice(emit_grp, plane_d);
    out_last_d = (state_d == StEmit) & (plane_d == '0) & emit_last;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StFill;
      grp0_q      <= '0;
      cnt_q       <= '0;
      plane_q     <= '0;
      closed_q    <= '0;
      glast_q     <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
`ifdef HUB75_SLICER_DBLBUF_EN
      grp1_q      <= '0;
      fb_q        <= 1'b0;
      eb_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      grp0_q      <= grp0_d;
      cnt_q       <= cnt_d;
      plane_q     <= plane_d;
      closed_q    <= closed_d;
      glast_q     <= glast_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= (state_d == StEmit);
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
`ifdef HUB75_SLICER_DBLBUF_EN
      grp1_q      <= grp1_d;
      fb_q        <= fb_d;
      eb_q        <= eb_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_plane = plane_q;
  assign bus.out_last  = out_last_q;
endmodule
